// File: rtl/video_route_ctrl.sv
// -----------------------------------------------------------------------------
// video_route_ctrl
//
// Purpose:
//   Owns the routing table that drives the video effect mux. A change request
//   names a destination node and its new source. The controller builds a
//   candidate table with that one entry replaced. It rejects malformed or
//   self-referencing requests. It then walks every node's source chain, one
//   hop per clock, to prove the candidate has no feedback loop. A candidate
//   that passes is committed atomically: all six source registers update on
//   the same edge.
//
// Optional feature (macro VIDEO_ROUTE_FRAME_SYNC_EN):
//   defined   -> a passing candidate waits in PENDING and is committed on the
//                edge that samples frame_start, so the mux never switches
//                mid-frame.
//   undefined -> no PENDING state; a passing candidate commits on the edge
//                that ends CHECK, and frame_start is ignored.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   req_valid      route-change request present
//   req_ready      request accepted this cycle (IDLE only, 0 during reset)
//   req_dst[2:0]   node to reconfigure (0 output .. 5 crush)
//   req_src[2:0]   new source (0 base, 1 delay .. 5 crush)
//   frame_start    one-cycle pulse at the first pixel of a frame
//   resp_valid     one-cycle pulse: request finished
//   resp_ok        qualifies resp_valid: 1 committed, 0 rejected
//   busy           request in validation, awaiting commit, or responding
//   *_src[2:0]     registered active routing table (six entries)
// -----------------------------------------------------------------------------
module video_route_ctrl #(
  parameter int MAX_HOPS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_dst,
  input  logic [2:0] req_src,
  input  logic       frame_start,
  output logic       resp_valid,
  output logic       resp_ok,
  output logic       busy,
  output logic [2:0] output_src,
  output logic [2:0] delay_src,
  output logic [2:0] reverb_src,
  output logic [2:0] filter_src,
  output logic [2:0] distortion_src,
  output logic [2:0] crush_src
);

  // Wide enough to hold MAX_HOPS itself.
  localparam int HW = $clog2(MAX_HOPS + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PENDING = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t          state_reg;
  logic [5:0][2:0] active_reg;
  logic [5:0][2:0] cand_reg;
  logic [2:0]      dst_reg;
  logic [2:0]      src_reg;
  logic            first_reg;   // first CHECK cycle: format checks only
  logic [2:0]      node_reg;    // node whose chain is being walked
  logic [2:0]      ptr_reg;     // current pointer along that chain
  logic [HW-1:0]   hops_reg;    // pointers dereferenced so far for node_reg
  logic            ready_reg;
  logic            busy_reg;
  logic            resp_valid_reg;
  logic            resp_ok_reg;

  // Table lookup by node code. Codes 6/7 never reach the walk because the
  // format check rejects them first; they read as base for safety.
  function automatic logic [2:0] lookup(input logic [5:0][2:0] tbl,
                                        input logic [2:0] idx);
    logic [2:0] val;
    val = 3'd0;
    case (idx)
      3'd0: val = tbl[0];
      3'd1: val = tbl[1];
      3'd2: val = tbl[2];
      3'd3: val = tbl[3];
      3'd4: val = tbl[4];
      3'd5: val = tbl[5];
      default: val = 3'd0;
    endcase
    return val;
  endfunction

  // Codes outside the node range, or a node feeding itself. The output node
  // taking the base source (0 <- 0) is the normal idle route, not a loop.
  logic bad_format;
  assign bad_format = (dst_reg > 3'd5) || (src_reg > 3'd5) ||
                      ((src_reg == dst_reg) && (dst_reg != 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      active_reg     <= '0;
      cand_reg       <= '0;
      dst_reg        <= 3'd0;
      src_reg        <= 3'd0;
      first_reg      <= 1'b0;
      node_reg       <= 3'd0;
      ptr_reg        <= 3'd0;
      hops_reg       <= '0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_ok_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg      <= 1'b1;
          busy_reg       <= 1'b0;
          resp_valid_reg <= 1'b0;
          resp_ok_reg    <= 1'b0;
          if (req_valid && ready_reg) begin
            for (int i = 0; i < 6; i++) begin
              cand_reg[i] <= (req_dst == 3'(i)) ? req_src : active_reg[i];
            end
            dst_reg   <= req_dst;
            src_reg   <= req_src;
            first_reg <= 1'b1;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= CHECK;
          end
        end

        CHECK: begin
          if (first_reg) begin
            first_reg <= 1'b0;
            if (bad_format) begin
              resp_valid_reg <= 1'b1;
              resp_ok_reg    <= 1'b0;
              state_reg      <= RESP;
            end else begin
              node_reg <= 3'd0;
              ptr_reg  <= cand_reg[0];
              hops_reg <= '0;
            end
          end else if (ptr_reg == 3'd0) begin
            // Current chain reached the base source.
            if (node_reg == 3'd5) begin
`ifdef VIDEO_ROUTE_FRAME_SYNC_EN
              state_reg <= PENDING;
`else
              active_reg     <= cand_reg;
              resp_valid_reg <= 1'b1;
              resp_ok_reg    <= 1'b1;
              state_reg      <= RESP;
`endif
            end else begin
              node_reg <= node_reg + 3'd1;
              ptr_reg  <= lookup(cand_reg, node_reg + 3'd1);
              hops_reg <= '0;
            end
          end else if (hops_reg == HW'(MAX_HOPS)) begin
            // Another hop would exceed the budget: treat as a loop.
            resp_valid_reg <= 1'b1;
            resp_ok_reg    <= 1'b0;
            state_reg      <= RESP;
          end else begin
            ptr_reg  <= lookup(cand_reg, ptr_reg);
            hops_reg <= hops_reg + HW'(1);
          end
        end

`ifdef VIDEO_ROUTE_FRAME_SYNC_EN
        PENDING: begin
          if (frame_start) begin
            active_reg     <= cand_reg;
            resp_valid_reg <= 1'b1;
            resp_ok_reg    <= 1'b1;
            state_reg      <= RESP;
          end
        end
`endif

        RESP: begin
          resp_valid_reg <= 1'b0;
          resp_ok_reg    <= 1'b0;
          busy_reg       <= 1'b0;
          ready_reg      <= 1'b1;
          state_reg      <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifndef VIDEO_ROUTE_FRAME_SYNC_EN
  // Without frame sync the frame pulse has no consumer.
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  assign req_ready      = ready_reg;
  assign busy           = busy_reg;
  assign resp_valid     = resp_valid_reg;
  assign resp_ok        = resp_ok_reg;
  assign output_src     = active_reg[0];
  assign delay_src      = active_reg[1];
  assign reverb_src     = active_reg[2];
  assign filter_src     = active_reg[3];
  assign distortion_src = active_reg[4];
  assign crush_src      = active_reg[5];

endmodule

// File: tb/tb_video_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_video_route_ctrl
//
// Purpose:
//   Self-checking bench for video_route_ctrl. A transaction-level model
//   decides each request's verdict and CHECK length from the routing rules.
//   One compare process checks every DUT output on every falling edge.
//   Directed scenarios add literal expectations; a randomized phase with
//   occasional resets follows.
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_video_route_ctrl;

  localparam int MAX_HOPS = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_dst = 3'd0;
  logic [2:0] req_src = 3'd0;
  logic       frame_start = 1'b0;
  logic       req_ready, resp_valid, resp_ok, busy;
  logic [2:0] output_src, delay_src, reverb_src, filter_src, distortion_src, crush_src;

  video_route_ctrl #(.MAX_HOPS(MAX_HOPS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_src(req_src), .frame_start(frame_start),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .busy(busy),
    .output_src(output_src), .delay_src(delay_src), .reverb_src(reverb_src),
    .filter_src(filter_src), .distortion_src(distortion_src), .crush_src(crush_src)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 validating, 2 waiting for frame, 3 responding
  int m_phase = 0;
  int m_cnt = 0;
  int m_len = 0;
  bit m_ok = 1'b0;
  bit m_ready = 1'b0;
  int m_table[6] = '{0, 0, 0, 0, 0, 0};
  int m_cand[6] = '{0, 0, 0, 0, 0, 0};

  // Verdict and CHECK duration: one cycle for the format check, then for each
  // node (dereferences + 1) cycles, or MAX_HOPS+1 cycles at a node whose
  // chain does not reach base within MAX_HOPS dereferences (walk stops there).
  function automatic void evaluate(input int dst, input int src);
    int p, d;
    for (int i = 0; i < 6; i++) m_cand[i] = (i == dst) ? src : m_table[i];
    m_len = 1;
    m_ok = 1'b1;
    if (dst > 5 || src > 5 || (src == dst && dst != 0)) begin
      m_ok = 1'b0;
      return;
    end
    for (int n = 0; n < 6; n++) begin
      p = m_cand[n];
      d = 0;
      while (p != 0 && d < MAX_HOPS) begin
        p = m_cand[p];
        d++;
      end
      if (p != 0) begin
        m_len += MAX_HOPS + 1;
        m_ok = 1'b0;
        return;
      end
      m_len += d + 1;
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0;
      m_ready = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        m_table[i] = 0;
        m_cand[i] = 0;
      end
    end else begin
      case (m_phase)
        0: if (m_ready && req_valid) begin
          evaluate(int'(req_dst), int'(req_src));
          m_cnt = m_len;
          m_phase = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            if (!m_ok) m_phase = 3;
            else begin
`ifdef VIDEO_ROUTE_FRAME_SYNC_EN
              m_phase = 2;
`else
              m_table = m_cand;
              m_phase = 3;
`endif
            end
          end
        end
        2: if (frame_start) begin
          m_table = m_cand;
          m_phase = 3;
        end
        default: m_phase = 0;
      endcase
      m_ready = (m_phase == 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("req_ready", int'(req_ready), int'(m_ready));
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("resp_valid", int'(resp_valid), int'(m_phase == 3));
    chk("resp_ok", int'(resp_ok), int'(m_phase == 3 && m_ok));
    chk("output_src", int'(output_src), m_table[0]);
    chk("delay_src", int'(delay_src), m_table[1]);
    chk("reverb_src", int'(reverb_src), m_table[2]);
    chk("filter_src", int'(filter_src), m_table[3]);
    chk("distortion_src", int'(distortion_src), m_table[4]);
    chk("crush_src", int'(crush_src), m_table[5]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [2:0] d, input logic [2:0] s);
    bit taken;
    taken = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_dst = d;
    req_src = s;
    for (int k = 0; k < 100 && !taken; k++) begin
      @(negedge clk);
      if (req_ready) taken = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!taken) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_resp(output bit ok);
    bit got;
    got = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        ok = resp_ok;
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  task automatic frame_pulse(input int delay_cycles);
    repeat (delay_cycles) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  function automatic logic [2:0] rand_code();
    if ($urandom_range(15) < 14) return 3'($urandom_range(5));
    return 3'(6 + $urandom_range(1));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int seen;

    // reset held, then released away from the clock edge
    repeat (3) @(negedge clk);
    chk("rst_ready_low", int'(req_ready), 0);
    chk("rst_busy_low", int'(busy), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(req_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_reverb", int'(reverb_src), 0);

    // reverb <- filter: valid, 8 CHECK cycles
    send(3'd2, 3'd3);
`ifdef VIDEO_ROUTE_FRAME_SYNC_EN
    repeat (18) @(negedge clk);
    chk("pend_reverb_unchanged", int'(reverb_src), 0);
    chk("pend_busy", int'(busy), 1);
    frame_pulse(0);
`endif
    wait_resp(ok);
    chk("r1_ok", int'(ok), 1);
    chk("r1_len", m_len, 8);
    chk("r1_reverb", int'(reverb_src), 3);

    // filter <- base
    send(3'd3, 3'd0);
`ifdef VIDEO_ROUTE_FRAME_SYNC_EN
    frame_pulse(15);
`endif
    wait_resp(ok);
    chk("r2_ok", int'(ok), 1);

    // filter <- reverb closes a loop: reject after 9 CHECK cycles
    send(3'd3, 3'd2);
    wait_resp(ok);
    chk("loop_ok", int'(ok), 0);
    chk("loop_len", m_len, 9);
    chk("loop_filter", int'(filter_src), 0);

    // self-reference and illegal source: rejected in the first CHECK cycle
    send(3'd4, 3'd4);
    wait_resp(ok);
    chk("self_ok", int'(ok), 0);
    chk("self_len", m_len, 1);
    send(3'd0, 3'd7);
    wait_resp(ok);
    chk("badsrc_ok", int'(ok), 0);
    chk("badsrc_output", int'(output_src), 0);
    chk("badsrc_reverb", int'(reverb_src), 3);

`ifdef VIDEO_ROUTE_FRAME_SYNC_EN
    // stalled in PENDING with a second request held
    send(3'd1, 3'd2);
    #1 req_valid = 1'b1;
    req_dst = 3'd4;
    req_src = 3'd0;
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (req_ready || resp_valid) seen++;
    end
    chk("stall_activity", seen, 0);
    chk("stall_busy", int'(busy), 1);
    @(posedge clk);
    #1 frame_start = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1 frame_start = 1'b0;
    wait_resp(ok);
    chk("stall_ok", int'(ok), 1);
    chk("stall_delay", int'(delay_src), 2);
`endif

    // reset while a request is in flight
    send(3'd5, 3'd1);
`ifdef VIDEO_ROUTE_FRAME_SYNC_EN
    repeat (30) @(negedge clk);
`else
    repeat (3) @(negedge clk);
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rst_no_resp", seen, 0);
    chk("rst_reverb_cleared", int'(reverb_src), 0);
    chk("rst_crush_cleared", int'(crush_src), 0);
    chk("rst_idle_ready", int'(req_ready), 1);

    // randomized traffic with rare resets
    repeat (4000) begin
      @(posedge clk);
      #1;
      req_valid = ($urandom_range(3) == 0);
      req_dst = rand_code();
      req_src = rand_code();
      frame_start = ($urandom_range(7) == 0);
      rst_n = ($urandom_range(999) != 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 1'b0;
    frame_start = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
